signed_divider_seq: RTL and testbench
=====================================

SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all flops update on its rising edge.
REQ-002 SHALL have rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have start, input, 1, request to begin a division; sampled only in IDLE.
REQ-004 SHALL have dividend, input, 16, two's-complement signed numerator; sampled with start.
REQ-005 SHALL have divisor, input, 16, two's-complement signed denominator; sampled with start.
REQ-006 SHALL have busy, output, 1, high while the state is not IDLE.
REQ-007 SHALL have done, output, 1, one-cycle pulse marking valid results.
REQ-008 SHALL have quotient, output, 16, signed quotient, registered.
REQ-009 SHALL have remainder, output, 16, signed remainder, registered.
REQ-010 SHALL have div_err, output, 1, divide-by-zero or overflow flag, registered (see Configuration).

Function
REQ-011 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-012 IDLE with start=1 at an edge SHALL capture |dividend|, |divisor| and both signs, load a 5-bit counter with 16, and enter CALC.
REQ-013 CALC SHALL perform one restoring shift-subtract step per cycle on a 17-bit partial remainder, producing one quotient bit MSB-first.
REQ-014 The counter SHALL decrement once per step; CALC SHALL hold for exactly 16 cycles, then enter FIX.
REQ-015 FIX SHALL apply signs: quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
REQ-016 FIX SHALL load quotient, remainder and div_err and enter DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be fixed: done high in the cycle after the 17th rising edge following the edge that sampled start; the next start is accepted on the edge that leaves DONE.
REQ-018 Magnitude arithmetic SHALL be 16-bit unsigned so that |-32768| = 32768 is represented exactly.
REQ-019 divisor = 0 SHALL yield quotient 16'hFFFF and remainder = dividend, with the same 17-edge latency.
REQ-020 dividend = 16'h8000 with divisor = 16'hFFFF SHALL yield quotient 16'h8000 and remainder 16'h0000.
REQ-021 start while busy=1 SHALL be ignored; the operands of the in-flight operation are unaffected.
REQ-022 quotient, remainder and div_err SHALL hold their last values until the next FIX; input changes while busy SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, counter 0, busy 0, done 0, quotient 0, remainder 0, div_err 0, and clear all internal datapath registers.
REQ-024 Reset during CALC or FIX SHALL abort the operation with no done pulse; after release the block SHALL accept start normally.

Configuration
REQ-025 Macro DIV_ERR_FLAG_EN defined: div_err SHALL be set in FIX when divisor = 0 or on the 16'h8000 / 16'hFFFF case, and cleared otherwise.
REQ-026 DIV_ERR_FLAG_EN undefined: div_err SHALL be tied to 0 and the detection logic omitted; quotient and remainder results are identical in both builds.

Verification
REQ-027 dividend 100, divisor 7, start pulse -> done 17 edges later; quotient 14, remainder 2, div_err 0.
REQ-028 dividend -100 (16'hFF9C), divisor 7 -> quotient 16'hFFF2 (-14), remainder 16'hFFFE (-2).
REQ-029 dividend 7, divisor 0 -> quotient 16'hFFFF, remainder 7; div_err 1 with DIV_ERR_FLAG_EN, 0 without.
REQ-030 dividend 16'h8000, divisor 16'hFFFF -> quotient 16'h8000, remainder 0; div_err 1 with the macro.
REQ-031 Start 1000/3, pulse start with 5/5 at cycle 4 -> exactly one done, at edge 17; quotient 333, remainder 1.
REQ-032 Start an operation and assert rst_n low at cycle 8 -> busy 0 and outputs 0 immediately, no done; then 9/-2 -> quotient -4 (16'hFFFC), remainder 1.

Source files
------------

// File: rtl/signed_divider_seq.sv
// Sequential 16-bit signed divider: restoring shift-subtract on magnitudes, one bit per cycle.
// Optional feature: define DIV_ERR_FLAG_EN to flag divide-by-zero and 16'h8000 / 16'hFFFF overflow.
module signed_divider_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_err
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [16:0] r_q, r_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;

    logic [16:0] r_shift;
    logic [17:0] trial;
    logic        b_zero;

`ifdef DIV_ERR_FLAG_EN
    logic        err_q, err_d;
`endif

    // Partial remainder shifted left with the next dividend bit; trial[17] set means r < b.
    assign r_shift = {r_q[15:0], a_q[15]};
    assign trial   = {1'b0, r_shift} - {2'b00, b_q};
    assign b_zero  = (b_q == 16'h0000);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ERR_FLAG_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_neg_d = dividend[15];
                    b_neg_d = divisor[15];
                    a_d     = dividend[15] ? -dividend : dividend;
                    b_d     = divisor[15] ? -divisor : divisor;
                    r_d     = '0;
                    cnt_d   = 5'd16;
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!trial[17]) begin
                    r_d = trial[16:0];
                    a_d = {a_q[14:0], 1'b1};
                end else begin
                    r_d = r_shift;
                    a_d = {a_q[14:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Remainder follows the dividend sign, so a zero divisor returns the dividend itself.
                if (b_zero) begin
                    quot_d = 16'hFFFF;
                end else begin
                    quot_d = (a_neg_q ^ b_neg_q) ? -a_q : a_q;
                end
                rem_d = a_neg_q ? -r_q[15:0] : r_q[15:0];
`ifdef DIV_ERR_FLAG_EN
                err_d = b_zero || (a_neg_q && b_neg_q && (a_q == 16'h8000) && (b_q == 16'h0001));
`endif
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_ERR_FLAG_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_ERR_FLAG_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ERR_FLAG_EN
    assign div_err   = err_q;
`else
    assign div_err   = 1'b0;
`endif

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_signed_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_err;

    int total = 0;
    int bad   = 0;

    signed_divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating signed division; zero divisor gives all-ones quotient and the dividend back.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic e);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = 16'hFFFF;
            r = a;
            e = 1'b1;
        end else begin
            q = 16'(ai / bi);
            r = 16'(ai % bi);
            e = (ai == -32768) && (bi == -1);
        end
`ifndef DIV_ERR_FLAG_EN
        e = 1'b0;
`endif
    endfunction

    // Launch one division; inj > 0 pulses a competing start with 5/5 on that cycle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int inj);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ee;
        int          first;
        int          ndone;
        model(a, b, eq, er, ee);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        first = -1;
        ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == inj) begin
                start    = 1'b1;
                dividend = 16'd5;
                divisor  = 16'd5;
            end else begin
                start    = 1'b0;
                dividend = 16'($urandom);
                divisor  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
            if (k == 1)  chk({tag, "_busy_hi"}, 40'(busy), 40'd1);
            if (k == 18) chk({tag, "_busy_lo"}, 40'(busy), 40'd0);
        end
        start = 1'b0;
        chk({tag, "_latency"}, 40'(first), 40'd17);
        chk({tag, "_ndone"}, 40'(ndone), 40'd1);
        chk({tag, "_quot"}, 40'(quotient), 40'(eq));
        chk({tag, "_rem"}, 40'(remainder), 40'(er));
        chk({tag, "_err"}, 40'(div_err), 40'(ee));
    endtask

    initial begin
        int ndone;
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset_state", {35'(busy), done, div_err, 3'(0)} | 40'(quotient) | 40'(remainder),
            40'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("d100_7", 16'd100, 16'd7, 0);
        chk("d100_7_q14", 40'(quotient), 40'd14);
        run_op("dm100_7", 16'hFF9C, 16'd7, 0);
        chk("dm100_7_qFFF2", 40'(quotient), 40'h0FFF2);
        run_op("d7_0", 16'd7, 16'd0, 0);
        run_op("dm7_0", 16'hFFF9, 16'd0, 0);
        run_op("ovf", 16'h8000, 16'hFFFF, 0);
        chk("ovf_q8000", 40'(quotient), 40'h08000);
        run_op("d1000_3_inj", 16'd1000, 16'd3, 4);
        chk("d1000_3_q333", 40'(quotient), 40'd333);

        // Abort mid-calculation with reset.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd5;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        chk("rst_abort", {35'(busy), done, div_err, 3'(0)} | 40'(quotient) | 40'(remainder),
            40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("rst_no_done", 40'(ndone), 40'd0);
        run_op("d9_m2", 16'd9, 16'hFFFE, 0);
        chk("d9_m2_qFFFC", 40'(quotient), 40'h0FFFC);

        run_op("min_1", 16'h8000, 16'd1, 0);
        run_op("min_min", 16'h8000, 16'h8000, 0);
        run_op("max_m1", 16'h7FFF, 16'hFFFF, 0);
        run_op("m1_min", 16'hFFFF, 16'h8000, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 4) ? 16'h0000 : 16'($urandom);
            if (i % 3 == 1) rb = 16'($urandom_range(1, 20));
            run_op($sformatf("rand%0d", i), ra, rb, (i % 4 == 2) ? 9 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
